// File: rtl/grid_move_gen.sv
// grid_move_gen: steps a tracked (a,b) grid position toward a latched target,
// issuing one strobed move command (axis/direction + step size) per move.
// Axis a is always settled before axis b. Step size is at most 3 per command.
module grid_move_gen #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target_a,
  input  logic [3:0] target_b,
  output logic [3:0] y,
  output logic       rot_event,
  output logic       busy,
  output logic       done,
  output logic [3:0] cur_a,
  output logic [3:0] cur_b
);

  typedef enum logic [2:0] {IDLE, CALC, SETUP, PULSE, GAP, DONE} state_t;

  localparam logic [3:0] PulseLast = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GapLast   = 4'(GAP_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [3:0] cur_a_q, cur_a_d, cur_b_q, cur_b_d;
  logic [3:0] tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d;
  logic [3:0] pulse_cnt_q, pulse_cnt_d, gap_cnt_q, gap_cnt_d;

  // Move-command selection, evaluated from the current position in CALC
  logic       a_sel, b_sel, up;
  logic [3:0] sel_cur, sel_tgt, diff;
  logic [1:0] step;

  // Apply a signed step, clamped to the receiver's 0..15 range
  function automatic logic [3:0] sat_step(input logic [3:0] cur,
                                          input logic [1:0] stp,
                                          input logic       neg);
    logic [4:0] sum;
    if (neg) begin
      sat_step = (cur < {2'b00, stp}) ? 4'd0 : cur - {2'b00, stp};
    end else begin
      sum      = {1'b0, cur} + {3'b000, stp};
      sat_step = sum[4] ? 4'd15 : sum[3:0];
    end
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= 4'd0;
      cur_a_q     <= 4'd0;
      cur_b_q     <= 4'd0;
      tgt_a_q     <= 4'd0;
      tgt_b_q     <= 4'd0;
      pulse_cnt_q <= 4'd0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      cur_a_q     <= cur_a_d;
      cur_b_q     <= cur_b_d;
      tgt_a_q     <= tgt_a_d;
      tgt_b_q     <= tgt_b_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next command: a axis first, step = min(3, distance), sign toward target
  always_comb begin
    a_sel   = (cur_a_q != tgt_a_q);
    b_sel   = (cur_b_q != tgt_b_q);
    sel_cur = a_sel ? cur_a_q : cur_b_q;
    sel_tgt = a_sel ? tgt_a_q : tgt_b_q;
    up      = (sel_tgt > sel_cur);
    diff    = up ? (sel_tgt - sel_cur) : (sel_cur - sel_tgt);
    step    = (diff > 4'd3) ? 2'd3 : diff[1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    state_d = (a_sel || b_sel) ? SETUP : DONE;
      SETUP:   state_d = PULSE;
      PULSE:   if (pulse_cnt_q == PulseLast) state_d = GAP;
      GAP:     if (gap_cnt_q == GapLast) state_d = CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: target latch, command build, position tracking, counters
  always_comb begin
    y_d         = y_q;
    cur_a_d     = cur_a_q;
    cur_b_d     = cur_b_q;
    tgt_a_d     = tgt_a_q;
    tgt_b_d     = tgt_b_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        tgt_a_d = target_a;
        tgt_b_d = target_b;
      end
      CALC: if (a_sel || b_sel) y_d = {step, a_sel, ~up};
      SETUP: begin
        // The edge leaving SETUP raises rot_event; the tracked position moves with it
        pulse_cnt_d = 4'd0;
        if (y_q[1]) cur_a_d = sat_step(cur_a_q, y_q[3:2], y_q[0]);
        else        cur_b_d = sat_step(cur_b_q, y_q[3:2], y_q[0]);
      end
      PULSE: begin
        pulse_cnt_d = pulse_cnt_q + 4'd1;
        if (pulse_cnt_q == PulseLast) gap_cnt_d = 4'd0;
      end
      GAP:     gap_cnt_d = gap_cnt_q + 4'd1;
      default: ;
    endcase
  end

  // Outputs decoded from state; busy also covers the accepting IDLE cycle
  always_comb begin
    rot_event = (state_q == PULSE);
    done      = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == SETUP) || (state_q == PULSE) ||
                (state_q == GAP)  || ((state_q == IDLE) && start);
  end

  assign y     = y_q;
  assign cur_a = cur_a_q;
  assign cur_b = cur_b_q;

endmodule
